// File: rtl/sha256_msg_schedule.sv
`default_nettype none
// ============================================================================
// Module      : sha256_msg_schedule
// Description : SHA-256 message schedule. Captures a 512-bit chunk and streams
//               the 64 expanded words W[0..63] over a valid/ready interface.
//               Optional stall counter enabled by defining MSCHED_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================

module sha256_msg_schedule #(
  parameter int WORD_W      = 32,
  parameter int ROUNDS      = 64,
  parameter int STALL_CNT_W = 32
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  output logic                  ap_ready,
  output logic                  ap_done,
  output logic                  ap_idle,
  input  logic [16*WORD_W-1:0]  chunk_in,
  output logic [WORD_W-1:0]     w_out,
  output logic [5:0]            w_idx,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic                  w_last
`ifdef MSCHED_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  generate
    if (WORD_W != 32 || ROUNDS <= 16 || ROUNDS > 64 || STALL_CNT_W < 1) begin : g_bad_params
      $error("sha256_msg_schedule: unsupported parameter values");
    end
  endgenerate

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   window_q [16];
  logic [WORD_W-1:0]   window_d [16];
  logic [5:0]          t_q, t_d;
  logic                ready_q, ready_d;
  logic [WORD_W-1:0]   w_new;

  // window[0] is the word being offered; window[15] receives the next expansion.
  assign w_new = sig1(window_q[14]) + window_q[9] + sig0(window_q[1]) + window_q[0];

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    ready_d = 1'b0;
    for (int i = 0; i < 16; i++) window_d[i] = window_q[i];

    case (state_q)
      ST_IDLE: begin
        if (ap_start) begin
          for (int i = 0; i < 16; i++) window_d[i] = chunk_in[(15-i)*WORD_W +: WORD_W];
          t_d     = 6'd0;
          ready_d = 1'b1;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (w_ready) begin
          for (int i = 0; i < 15; i++) window_d[i] = window_q[i+1];
          window_d[15] = w_new;
          if (t_q == LAST_IDX) state_d = ST_DONE;
          else                 t_d     = t_q + 6'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= ST_IDLE;
      t_q     <= 6'd0;
      ready_q <= 1'b0;
      for (int i = 0; i < 16; i++) window_q[i] <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      ready_q <= ready_d;
      for (int i = 0; i < 16; i++) window_q[i] <= window_d[i];
    end
  end

  assign ap_idle  = (state_q == ST_IDLE);
  assign ap_done  = (state_q == ST_DONE);
  assign ap_ready = ready_q;
  assign w_valid  = (state_q == ST_EMIT);
  assign w_out    = w_valid ? window_q[0] : '0;
  assign w_idx    = t_q;
  assign w_last   = w_valid && (t_q == LAST_IDX);

`ifdef MSCHED_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (ap_idle && ap_start)
      stall_cnt_d = '0;
    else if (w_valid && !w_ready && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire
